// File: rtl/vector_mem_sequencer.sv
// Memory-stage access sequencer: one beat for scalar ops, LANES consecutive
// element beats for vector ops, with load assembly and a pipeline stall request.
module vector_mem_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int ELEM_W     = 32,
  parameter int LANES      = 4,
  parameter int ELEM_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      modeSel,
  input  logic                      isStore,
  input  logic [ADDR_W-1:0]         baseAddr,
  input  logic [LANES*ELEM_W-1:0]   storeData,
  output logic                      memEn,
  output logic                      memWe,
  output logic [ADDR_W-1:0]         memAddr,
  output logic [ELEM_W-1:0]         memWdata,
  input  logic [ELEM_W-1:0]         memRdata,
  output logic [LANES*ELEM_W-1:0]   loadData,
  output logic                      done,
  output logic                      stall
);

  localparam int BEAT_W = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      mode_q, mode_d;
  logic                      is_store_q, is_store_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [LANES*ELEM_W-1:0]   wdata_q, wdata_d;
  logic [LANES*ELEM_W-1:0]   load_q, load_d;
  logic                      cap_q, cap_d;
  logic [BEAT_W-1:0]         cap_lane_q, cap_lane_d;
  logic [BEAT_W-1:0]         last_beat_s;
  logic                      access_s;

  // State and operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      mode_q     <= 1'b0;
      is_store_q <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      load_q     <= '0;
      cap_q      <= 1'b0;
      cap_lane_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mode_q     <= mode_d;
      is_store_q <= is_store_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      cap_q      <= cap_d;
      cap_lane_q <= cap_lane_d;
    end
  end

  // Next-state, operand latch and load capture
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mode_d      = mode_q;
    is_store_d  = is_store_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    load_d      = load_q;
    last_beat_s = mode_q ? BEAT_W'(LANES - 1) : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCESS;
          beat_d     = '0;
          mode_d     = modeSel;
          is_store_d = isStore;
          base_d     = baseAddr;
          wdata_d    = storeData;
          load_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (beat_q == last_beat_s) begin
          state_d = is_store_q ? S_DONE : S_DRAIN;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_DRAIN:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Read data for the beat issued last cycle arrives now; never overlaps the IDLE clear.
    cap_d      = (state_q == S_ACCESS) && !is_store_q;
    cap_lane_d = beat_q;
    if (cap_q) begin
      load_d[int'(cap_lane_q)*ELEM_W +: ELEM_W] = memRdata;
    end else begin
      load_d = load_d;
    end
  end

  assign access_s = (state_q == S_ACCESS);
  assign memEn    = access_s;
  assign memWe    = access_s & is_store_q;
  assign memAddr  = access_s ? (base_q + ADDR_W'(beat_q) * ADDR_W'(ELEM_BYTES)) : '0;
  assign memWdata = (access_s && is_store_q) ? wdata_q[int'(beat_q)*ELEM_W +: ELEM_W] : '0;
  assign loadData = load_q;
  assign done     = (state_q == S_DONE);
  // Gated by rst so that a pending start cannot hold the pipeline during reset.
  assign stall    = rst & (((state_q == S_IDLE) & start) | access_s | (state_q == S_DRAIN));

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench: expected memory accesses queued per op and compared
// by a bus monitor; done timing, stall and loadData checked per scenario.
module tb_vector_mem_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          modeSel;
  logic          isStore;
  logic [31:0]   baseAddr;
  logic [127:0]  storeData;
  logic          memEn;
  logic          memWe;
  logic [31:0]   memAddr;
  logic [31:0]   memWdata;
  logic [31:0]   memRdata;
  logic [127:0]  loadData;
  logic          done;
  logic          stall;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  logic [31:0] ram [logic [31:0]];

  logic        en_s, we_s;
  logic [31:0] a_s, wd_s;

  vector_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .modeSel(modeSel), .isStore(isStore),
    .baseAddr(baseAddr), .storeData(storeData), .memEn(memEn), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata),
    .loadData(loadData), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // Bus monitor: every memEn cycle must match the next expected access
  always @(negedge clk) begin
    en_s = memEn; we_s = memWe; a_s = memAddr; wd_s = memWdata;
    checks++;
    if (memEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access addr=%h we=%b wdata=%h required=no access", memAddr, memWe, memWdata);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        if ({memWe, memAddr, memWdata} !== {e.we, e.addr, e.wdata}) begin
          errors++;
          $display("FAIL access got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                   memWe, memAddr, memWdata, e.we, e.addr, e.wdata);
        end
      end
    end else if (memWe !== 1'b0 || memAddr !== 32'h0 || memWdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_bus got we=%b addr=%h wdata=%h required all 0", memWe, memAddr, memWdata);
    end
  end

  // Synchronous RAM model driven from the bus values sampled mid-cycle
  always @(posedge clk) begin
    if (en_s === 1'b1) begin
      if (we_s) ram[a_s] = wd_s;
      else memRdata <= ram.exists(a_s) ? ram[a_s] : 32'h0;
    end
  end

  task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    acc_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Drives one op from IDLE, scrambles inputs after acceptance, records done cycle and stall trace
  task automatic run_op(input logic m, input logic st, input logic [31:0] base, input logic [127:0] data,
                        output int done_cyc, output logic [31:0] stall_bits);
    done_cyc   = -1;
    stall_bits = 32'h0;
    @(posedge clk); #1;
    start = 1'b1; modeSel = m; isStore = st; baseAddr = base; storeData = data;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      stall_bits[c] = stall;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0; modeSel = 1'($urandom); isStore = 1'($urandom);
      baseAddr = $urandom; storeData = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_access got %0d pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; modeSel = 1'b1; isStore = 1'b1;
    baseAddr = 32'h1234; storeData = '1;
    #3;
    checks++;
    if ({done, memEn, memWe, memAddr, memWdata, stall, loadData} !== '0) begin
      errors++;
      $display("FAIL reset_outputs done=%b memEn=%b stall=%b addr=%h loadData=%h required all 0",
               done, memEn, stall, memAddr, loadData);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_scalar_store;
    int d; logic [31:0] sb;
    push_acc(1'b1, 32'h100, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 32'h100, {96'h0, 32'hDEADBEEF}, d, sb);
    checks++;
    if (d != 2) begin errors++; $display("FAIL sstore_done got %0d required 2", d); end
    checks++;
    if (sb[2:0] !== 3'b011) begin errors++; $display("FAIL sstore_stall got %b required 011", sb[2:0]); end
    check_drained("sstore");
  endtask

  task automatic test_vector_load;
    int d; logic [31:0] sb;
    for (int i = 0; i < 4; i++) push_acc(1'b0, 32'h200 + 32'(i * 4), 32'h0);
    run_op(1'b1, 1'b0, 32'h200, '1, d, sb);
    checks++;
    if (d != 6) begin errors++; $display("FAIL vload_done got %0d required 6", d); end
    checks++;
    if (sb[6:0] !== 7'h3F) begin errors++; $display("FAIL vload_stall got %b required 0111111", sb[6:0]); end
    checks++;
    if (loadData !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
      errors++; $display("FAIL vload_data got %h required 00000044000000330000002200000011", loadData);
    end
    check_drained("vload");
  endtask

  task automatic test_vector_store_wrap;
    int d; logic [31:0] sb;
    logic [127:0] data;
    logic [31:0] addrs [4];
    data = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    addrs[0] = 32'hFFFFFFF8; addrs[1] = 32'hFFFFFFFC; addrs[2] = 32'h0; addrs[3] = 32'h4;
    for (int i = 0; i < 4; i++) push_acc(1'b1, addrs[i], 32'hCAFE0000 + 32'(i));
    run_op(1'b1, 1'b1, 32'hFFFFFFF8, data, d, sb);
    checks++;
    if (d != 5) begin errors++; $display("FAIL vstore_done got %0d required 5", d); end
    checks++;
    if (sb[5:0] !== 6'h1F) begin errors++; $display("FAIL vstore_stall got %b required 011111", sb[5:0]); end
    check_drained("vstore");
  endtask

  task automatic test_scalar_load;
    int d; logic [31:0] sb;
    push_acc(1'b0, 32'h40, 32'h0);
    run_op(1'b0, 1'b0, 32'h40, '1, d, sb);
    checks++;
    if (d != 3) begin errors++; $display("FAIL sload_done got %0d required 3", d); end
    checks++;
    if (loadData !== {96'h0, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sload_data got %h required lane0 a5a5a5a5 others 0", loadData);
    end
    check_drained("sload");
  endtask

  task automatic test_back_to_back;
    logic [31:0] done_bits, stall_bits;
    logic [127:0] ld6, ld9;
    done_bits = 32'h0; stall_bits = 32'h0; ld6 = '1; ld9 = '1;
    for (int i = 0; i < 4; i++) push_acc(1'b0, 32'h200 + 32'(i * 4), 32'h0);
    push_acc(1'b1, 32'h300, 32'h5EC0DD00);
    @(posedge clk); #1;
    start = 1'b1; modeSel = 1'b1; isStore = 1'b0; baseAddr = 32'h200; storeData = '1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      done_bits[c]  = done;
      stall_bits[c] = stall;
      if (c == 6) ld6 = loadData;
      if (c == 9) ld9 = loadData;
      @(posedge clk); #1;
      modeSel = 1'b0; isStore = 1'b1; baseAddr = 32'h300; storeData = {96'h0, 32'h5EC0DD00};
      if (c >= 7) start = 1'b0;
    end
    checks++;
    if (done_bits[13:0] !== 14'b00_0010_0100_0000) begin
      errors++; $display("FAIL b2b_done got %b required 00001001000000", done_bits[13:0]);
    end
    checks++;
    if (stall_bits[13:0] !== 14'b00_0001_1011_1111) begin
      errors++; $display("FAIL b2b_stall got %b required 00000110111111", stall_bits[13:0]);
    end
    checks++;
    if (ld6 !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
      errors++; $display("FAIL b2b_load got %h required 00000044000000330000002200000011", ld6);
    end
    checks++;
    if (ld9 !== 128'h0) begin errors++; $display("FAIL b2b_load_clear got %h required 0", ld9); end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_op;
    int d; logic [31:0] sb;
    logic saw;
    push_acc(1'b0, 32'h200, 32'h0);
    push_acc(1'b0, 32'h204, 32'h0);
    @(posedge clk); #1;
    start = 1'b1; modeSel = 1'b1; isStore = 1'b0; baseAddr = 32'h200; storeData = '0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0; start = 1'b1;
    #1;
    checks++;
    if ({memEn, stall, loadData} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs memEn=%b stall=%b loadData=%h required all 0", memEn, stall, loadData);
    end
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || memEn !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin errors++; $display("FAIL rst_mid_quiet got done/memEn activity required none"); end
    start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    check_drained("rst_mid");
    push_acc(1'b1, 32'h180, 32'h0BADF00D);
    run_op(1'b0, 1'b1, 32'h180, {96'h0, 32'h0BADF00D}, d, sb);
    checks++;
    if (d != 2) begin errors++; $display("FAIL rst_recover_done got %0d required 2", d); end
    check_drained("rst_recover");
  endtask

  initial begin
    memRdata = 32'h0;
    ram[32'h200] = 32'h11; ram[32'h204] = 32'h22;
    ram[32'h208] = 32'h33; ram[32'h20C] = 32'h44;
    ram[32'h40]  = 32'hA5A5A5A5;
    test_reset();
    test_scalar_store();
    test_vector_load();
    test_vector_store_wrap();
    test_scalar_load();
    test_back_to_back();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
